// File: rtl/pc_sequencer.sv
// Sequences PC/return-stack strobes for one decoded flow-control op at a time; 2/3/4 cycles accept-to-accept (1-word, 2-word, 2-word call).
// Backpressure: op_ready only in IDLE; mem_ready=0 stalls FETCH2/EXEC with all strobes low.
module pc_sequencer #(
  parameter int STACK_DEPTH = 3,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_kind,
  input  logic              op_two_word,
  input  logic [ADDR_W-1:0] op_target,
  input  logic              op_cond,
  input  logic              mem_ready,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              stack_push,
  output logic              stack_pop,
  output logic [1:0]        depth,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_ill,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH2 = 2'd1,
    S_EXEC   = 2'd2,
    S_PUSH   = 2'd3
  } state_t;

  localparam logic [2:0] K_SEQ = 3'd0;
  localparam logic [2:0] K_JUN = 3'd1;
  localparam logic [2:0] K_JMS = 3'd2;
  localparam logic [2:0] K_BBL = 3'd3;
  localparam logic [2:0] K_JCN = 3'd4;
  localparam logic [1:0] DEPTH_MAX = 2'(STACK_DEPTH);

  state_t              state, state_nxt;
  logic [2:0]          cap_kind;
  logic                cap_two_word;
  logic [ADDR_W-1:0]   cap_target;
  logic                cap_cond;
  logic [1:0]          depth_q, depth_nxt;
  logic                inc_c, load_c, push_c, pop_c;
  logic                set_ovf, set_unf, set_ill;
  logic                accept;

  assign op_ready = (state == S_IDLE);
  assign accept   = op_ready && op_valid;

  always_comb begin
    state_nxt = state;
    depth_nxt = depth_q;
    inc_c     = 1'b0;
    load_c    = 1'b0;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    set_ill   = 1'b0;
    case (state)
      S_IDLE: begin
        if (op_valid) state_nxt = op_two_word ? S_FETCH2 : S_EXEC;
      end
      S_FETCH2: begin
        if (mem_ready) begin
          inc_c     = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (mem_ready) begin
          state_nxt = S_IDLE;
          case (cap_kind)
            K_SEQ: inc_c = 1'b1;
            K_JUN: load_c = 1'b1;
            K_JCN: begin
              load_c = cap_cond;
              inc_c  = !cap_cond;
            end
            K_JMS: begin
              // Step past the call so PC holds the return address for PUSH.
              inc_c     = 1'b1;
              state_nxt = S_PUSH;
            end
            K_BBL: begin
              if (depth_q != 2'd0) begin
                pop_c     = 1'b1;
                depth_nxt = depth_q - 2'd1;
              end else begin
                inc_c   = 1'b1;
                set_unf = 1'b1;
              end
            end
            default: begin
              inc_c   = 1'b1;
              set_ill = 1'b1;
            end
          endcase
        end
      end
      S_PUSH: begin
        state_nxt = S_IDLE;
        if (depth_q < DEPTH_MAX) begin
          push_c    = 1'b1;
          load_c    = 1'b1;
          depth_nxt = depth_q + 2'd1;
        end else begin
          set_ovf = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are suppressed while reset is held so an abandoned op cannot leak a pulse.
  assign pc_inc     = rst_n && inc_c;
  assign pc_load    = rst_n && load_c;
  assign stack_push = rst_n && push_c;
  assign stack_pop  = rst_n && pop_c;
  assign pc_target  = cap_target;
  assign depth      = depth_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      depth_q      <= 2'd0;
      cap_kind     <= 3'd0;
      cap_two_word <= 1'b0;
      cap_target   <= '0;
      cap_cond     <= 1'b0;
      err_ovf      <= 1'b0;
      err_unf      <= 1'b0;
      err_ill      <= 1'b0;
    end else begin
      state   <= state_nxt;
      depth_q <= depth_nxt;
      if (accept) begin
        cap_kind     <= op_kind;
        cap_two_word <= op_two_word;
        cap_target   <= op_target;
        cap_cond     <= op_cond;
      end
      err_ovf <= set_ovf || (err_ovf && !err_clr);
      err_unf <= set_unf || (err_unf && !err_clr);
      err_ill <= set_ill || (err_ill && !err_clr);
    end
  end

endmodule
